// File: rtl/sifive_assert_event_reporter_if.sv
// Report channel carrying one violation record per valid/ready transfer.
//   rpt_valid  head record available (driven by the reporter)
//   rpt_ready  sink accepts the head record (driven by the sink)
//   rpt_id     lowest failing checker index of the head record
//   rpt_mask   all failing checkers of the head record
//   rpt_time   timestamp of the head record's violation cycle
// master = reporter side, slave = sink side.
interface sifive_assert_event_reporter_if #(
  parameter int NUM_CHK = 4,
  parameter int TS_W    = 32
);
  logic                rpt_valid;
  logic                rpt_ready;
  logic [3:0]          rpt_id;
  logic [NUM_CHK-1:0]  rpt_mask;
  logic [TS_W-1:0]     rpt_time;

  modport master (
    output rpt_valid,
    output rpt_id,
    output rpt_mask,
    output rpt_time,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_id,
    input  rpt_mask,
    input  rpt_time,
    output rpt_ready
  );
endinterface

// File: rtl/sifive_assert_event_reporter.sv
// Captures protocol-checker violations (an ok term low while armed) as
// timestamped records, buffers them in a small FIFO and drains them over a
// valid/ready report channel, so violations remain visible on builds where
// simulation-only fatal checks are compiled out.
// Ports:
//   clock      sole clock, all logic on posedge
//   reset      synchronous, active-high
//   chk_ok     per-checker condition, 1 = legal, 0 = violation
//   arm        capture enable (level)
//   clear      one-cycle pulse: flush FIFO, zero counters and flags, go IDLE
//   rpt        report channel (master side): valid/ready + id/mask/time
//   err_count  violating cycles seen while armed or frozen (saturating)
//   overflow   sticky: a record was dropped because the FIFO was full
//   frozen     capture stopped after the first violation (STOP_ON_ERR=1)
module sifive_assert_event_reporter #(
  parameter int NUM_CHK     = 4,
  parameter int TS_W        = 32,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CHK-1:0]   chk_ok,
  input  logic                 arm,
  input  logic                 clear,
  sifive_assert_event_reporter_if.master rpt,
  output logic [CNT_W-1:0]     err_count,
  output logic                 overflow,
  output logic                 frozen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;  // occupancy 0..DEPTH, so all entries are usable

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t              state_reg;
  logic [TS_W-1:0]     ts_reg;
  logic [CW-1:0]       count_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [AW-1:0]       wr_ptr_reg;
  logic [CNT_W-1:0]    err_cnt_reg;
  logic                overflow_reg;

  logic [3:0]          mem_id   [DEPTH];
  logic [NUM_CHK-1:0]  mem_mask [DEPTH];
  logic [TS_W-1:0]     mem_time [DEPTH];

  logic [NUM_CHK-1:0]  fail_mask;
  logic [3:0]          fail_id;
  logic                any_fail;
  logic                viol;
  logic                count_hit;
  logic                not_empty;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  assign fail_mask = ~chk_ok;
  assign any_fail  = |fail_mask;
  // Uses same-cycle inputs: a violation is recorded in the very cycle it occurs.
  assign viol      = (state_reg == ARMED) && any_fail;
  // The counter keeps counting after a freeze, only IDLE ignores violations.
  assign count_hit = ((state_reg == ARMED) || (state_reg == FROZEN)) && any_fail;

  // Lowest failing index: scan from the top so the lowest hit wins.
  always_comb begin
    fail_id = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (fail_mask[i]) begin
        fail_id = 4'(i);
      end
    end
  end

  assign not_empty = (count_reg != '0);
  assign full      = (count_reg == CW'(DEPTH));
  // clear wins over both pop and push in the same cycle.
  assign pop       = not_empty && rpt.rpt_ready && !clear;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push      = viol && (!full || pop) && !clear;
  assign drop      = viol && full && !pop && !clear;

  // Head of FIFO; all fields read as zero while empty.
  assign rpt.rpt_valid = not_empty;
  assign rpt.rpt_id    = not_empty ? mem_id[rd_ptr_reg]   : '0;
  assign rpt.rpt_mask  = not_empty ? mem_mask[rd_ptr_reg] : '0;
  assign rpt.rpt_time  = not_empty ? mem_time[rd_ptr_reg] : '0;

  assign err_count = err_cnt_reg;
  assign overflow  = overflow_reg;
  assign frozen    = (state_reg == FROZEN);

  // Record storage: no reset needed, the occupancy counter guards every read.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_id[wr_ptr_reg]   <= fail_id;
      mem_mask[wr_ptr_reg] <= fail_mask;
      mem_time[wr_ptr_reg] <= ts_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      ts_reg       <= '0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      err_cnt_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      // Timestamp free-runs and is deliberately untouched by clear.
      ts_reg <= ts_reg + TS_W'(1);

      if (clear) begin
        state_reg    <= IDLE;
        count_reg    <= '0;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        err_cnt_reg  <= '0;
        overflow_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (arm) begin
              state_reg <= ARMED;
            end
          end
          ARMED: begin
            // A violation freezes even if arm drops in the same cycle.
            if (viol && (STOP_ON_ERR != 0)) begin
              state_reg <= FROZEN;
            end else if (!arm) begin
              state_reg <= IDLE;
            end
          end
          FROZEN: begin
            state_reg <= FROZEN;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase

        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase

        if (drop) begin
          overflow_reg <= 1'b1;
        end
        if (count_hit && (err_cnt_reg != '1)) begin
          err_cnt_reg <= err_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule
